// File: rtl/crossbar_pkg.sv
// Shared types for the crossbar route unit and its per-destination skid buffers.
package crossbar_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } buf_state_e;

endpackage

// File: rtl/stream_skid_buffer.sv
// Two-entry stream skid buffer: head register drives the output, skid register absorbs one extra beat.
module stream_skid_buffer
    import crossbar_pkg::*;
#(
    parameter int unsigned PAYLOAD_WIDTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [PAYLOAD_WIDTH-1:0] push_payload_i,
    output logic                     space_o,
    input  logic                     pop_ready_i,
    output logic                     valid_o,
    output logic [PAYLOAD_WIDTH-1:0] payload_o
);

    buf_state_e               state;
    logic [PAYLOAD_WIDTH-1:0] head;
    logic [PAYLOAD_WIDTH-1:0] skid;
    logic                     pop;

    // Status decodes come from registered state only, so space never depends on pop_ready_i.
    assign valid_o   = (state != EMPTY);
    assign space_o   = (state != FULL);
    assign payload_o = head;
    assign pop       = valid_o && pop_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= EMPTY;
            head  <= '0;
            skid  <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (push_i) begin
                        head  <= push_payload_i;
                        state <= ONE;
                    end
                end
                ONE: begin
                    if (push_i && !pop) begin
                        skid  <= push_payload_i;
                        state <= FULL;
                    end else if (!push_i && pop) begin
                        state <= EMPTY;
                    end else if (push_i && pop) begin
                        head  <= push_payload_i;
                    end
                end
                FULL: begin
                    if (pop) begin
                        head  <= skid;
                        state <= ONE;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/crossbar_route_unit.sv
// Crossbar datapath: steers granted source beats into one skid buffer per destination.
module crossbar_route_unit
    import crossbar_pkg::*;
#(
    parameter int unsigned T_DATA_WIDTH = 8,
    parameter int unsigned S_DATA_COUNT = 2,
    parameter int unsigned M_DATA_COUNT = 3
) (
    input  logic                                      clk_i,
    input  logic                                      rst_i,
    input  logic [S_DATA_COUNT-1:0][T_DATA_WIDTH-1:0] s_data_i,
    input  logic [S_DATA_COUNT-1:0][$clog2(M_DATA_COUNT)-1:0] s_dest_i,
    input  logic [S_DATA_COUNT-1:0]                   s_last_i,
    input  logic [S_DATA_COUNT-1:0]                   s_valid_i,
    output logic [S_DATA_COUNT-1:0]                   s_ready_o,
    input  logic [M_DATA_COUNT-1:0][$clog2(S_DATA_COUNT)-1:0] grant_i,
    input  logic [M_DATA_COUNT-1:0]                   arbiter_ready_i,
    output logic [M_DATA_COUNT-1:0][T_DATA_WIDTH-1:0] m_data_o,
    output logic [M_DATA_COUNT-1:0][$clog2(S_DATA_COUNT)-1:0] m_id_o,
    output logic [M_DATA_COUNT-1:0]                   m_last_o,
    output logic [M_DATA_COUNT-1:0]                   m_valid_o,
    input  logic [M_DATA_COUNT-1:0]                   m_ready_i
);

    localparam int unsigned T_ID___WIDTH  = $clog2(S_DATA_COUNT);
    localparam int unsigned T_DEST_WIDTH  = $clog2(M_DATA_COUNT);
    localparam int unsigned PAYLOAD_WIDTH = T_DATA_WIDTH + 1 + T_ID___WIDTH;

    logic [M_DATA_COUNT-1:0][S_DATA_COUNT-1:0]  route;
    logic [S_DATA_COUNT-1:0][M_DATA_COUNT-1:0]  accept;
    logic [M_DATA_COUNT-1:0]                    space;
    logic [M_DATA_COUNT-1:0]                    push;
    logic [M_DATA_COUNT-1:0]                    buf_valid;
    logic [M_DATA_COUNT-1:0][PAYLOAD_WIDTH-1:0] push_payload;
    logic [M_DATA_COUNT-1:0][PAYLOAD_WIDTH-1:0] buf_payload;

    // A destination index outside 0..M_DATA_COUNT-1 never matches any i, so such beats stay unaccepted.
    for (genvar i = 0; i < M_DATA_COUNT; i++) begin : g_route_i
        for (genvar j = 0; j < S_DATA_COUNT; j++) begin : g_route_j
            assign route[i][j]  = arbiter_ready_i[i]
                               && (grant_i[i] == T_ID___WIDTH'(j))
                               && (s_dest_i[j] == T_DEST_WIDTH'(i))
                               && s_valid_i[j];
            assign accept[j][i] = route[i][j] && space[i];
        end
    end

    for (genvar j = 0; j < S_DATA_COUNT; j++) begin : g_ready
        assign s_ready_o[j] = !rst_i && (|accept[j]);
    end

    // The grant selects the only source that can route here, and doubles as the beat's id.
    for (genvar i = 0; i < M_DATA_COUNT; i++) begin : g_dest
        assign push[i]         = !rst_i && space[i] && (|route[i]);
        assign push_payload[i] = {s_data_i[grant_i[i]], s_last_i[grant_i[i]], grant_i[i]};

        stream_skid_buffer #(
            .PAYLOAD_WIDTH (PAYLOAD_WIDTH)
        ) u_skid (
            .clk_i          (clk_i),
            .rst_i          (rst_i),
            .push_i         (push[i]),
            .push_payload_i (push_payload[i]),
            .space_o        (space[i]),
            .pop_ready_i    (m_ready_i[i]),
            .valid_o        (buf_valid[i]),
            .payload_o      (buf_payload[i])
        );

        assign {m_data_o[i], m_last_o[i], m_id_o[i]} = buf_payload[i];
        assign m_valid_o[i] = buf_valid[i] && !rst_i;
    end

endmodule
